// File: rtl/rect_plotter.sv
`default_nettype none
// ============================================================================
//  Module   : rect_plotter
//  Purpose  : Rectangle pixel-stream generator for vga_adapter (160x120,
//             3-bit colour). Accepts one request per start handshake and
//             emits one pixel per enabled cycle in raster order. Off-screen
//             pixels are clipped: their slot is consumed but plot stays low.
//             A one-cycle done pulse marks the end of each request.
//  Ports    : clk, reset (sync, active-low)
//             start, x0[7:0], y0[6:0], width[7:0], height[6:0], colour_in[2:0]
//             step        - pixel-advance enable
//             outline     - perimeter-only request (RECT_OUTLINE_EN builds)
//             busy, done  - request status
//             x[7:0], y[6:0], colour[2:0], plot - pixel write to vga_adapter
//  Options  : `define RECT_OUTLINE_EN adds the outline input
//  Revision : 1.0 - initial release
// ============================================================================
module rect_plotter #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] x0,
   input  logic [6:0] y0,
   input  logic [7:0] width,
   input  logic [6:0] height,
   input  logic [2:0] colour_in,
   input  logic       step,
`ifdef RECT_OUTLINE_EN
   input  logic       outline,
`endif
   output logic       busy,
   output logic       done,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot
);

   localparam logic [8:0] c_SCREEN_W = 9'(SCREEN_W);
   localparam logic [7:0] c_SCREEN_H = 8'(SCREEN_H);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DRAW = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     r_state;

   // Latched request
   logic [7:0] r_x0;
   logic [6:0] r_y0;
   logic [7:0] r_w;
   logic [6:0] r_h;
   logic [2:0] r_col;
`ifdef RECT_OUTLINE_EN
   logic       r_outline;
`endif

   // Scan position within the rectangle
   logic [7:0] r_dx;
   logic [6:0] r_dy;

   // Registered outputs
   logic       r_busy;
   logic       r_done;
   logic [7:0] r_x;
   logic [6:0] r_y;
   logic [2:0] r_colour;
   logic       r_plot;

   // Sums carry one extra bit so a wrapped coordinate can never look visible
   logic [8:0] w_sx;
   logic [7:0] w_sy;
   logic       w_row_end;
   logic       w_last_row;
   logic       w_visible;
   logic [7:0] w_dx_next;

   assign w_sx       = {1'b0, r_x0} + {1'b0, r_dx};
   assign w_sy       = {1'b0, r_y0} + {1'b0, r_dy};
   assign w_row_end  = (r_dx == (r_w - 8'd1));
   assign w_last_row = (r_dy == (r_h - 7'd1));
   assign w_visible  = (w_sx < c_SCREEN_W) && (w_sy < c_SCREEN_H);

   // Next column when the current row is not finished. In outline mode an
   // interior row jumps straight from the left edge to the right edge.
   always_comb begin
      w_dx_next = r_dx + 8'd1;
`ifdef RECT_OUTLINE_EN
      if (r_outline && (r_dy != 7'd0) && !w_last_row)
         w_dx_next = r_w - 8'd1;
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_x0     <= 8'd0;
         r_y0     <= 7'd0;
         r_w      <= 8'd0;
         r_h      <= 7'd0;
         r_col    <= 3'd0;
`ifdef RECT_OUTLINE_EN
         r_outline <= 1'b0;
`endif
         r_dx     <= 8'd0;
         r_dy     <= 7'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_x      <= 8'd0;
         r_y      <= 7'd0;
         r_colour <= 3'd0;
         r_plot   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               r_plot <= 1'b0;
               if (start) begin
                  r_x0   <= x0;
                  r_y0   <= y0;
                  r_w    <= width;
                  r_h    <= height;
                  r_col  <= colour_in;
`ifdef RECT_OUTLINE_EN
                  r_outline <= outline;
`endif
                  r_dx   <= 8'd0;
                  r_dy   <= 7'd0;
                  r_busy <= 1'b1;
                  if ((width == 8'd0) || (height == 7'd0)) begin
                     // Empty request completes immediately with no pixels
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_DRAW;
                  end
               end else begin
                  r_busy <= 1'b0;
               end
            end

            S_DRAW: begin
               if (step) begin
                  r_x      <= w_sx[7:0];
                  r_y      <= w_sy[6:0];
                  r_colour <= r_col;
                  r_plot   <= w_visible;
                  if (w_row_end) begin
                     r_dx <= 8'd0;
                     r_dy <= r_dy + 7'd1;
                     if (w_last_row) begin
                        // Last pixel's plot and done land in the same cycle
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                     end
                  end else begin
                     r_dx <= w_dx_next;
                  end
               end else begin
                  r_plot <= 1'b0;
               end
            end

            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_plot  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_plot  <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign x      = r_x;
   assign y      = r_y;
   assign colour = r_colour;
   assign plot   = r_plot;

endmodule
`default_nettype wire

// File: tb/tb_rect_plotter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rect_plotter
//  Purpose  : Directed self-checking bench for rect_plotter. Inputs change
//             1 time unit after each rising edge; outputs are sampled there.
//  Options  : `define RECT_OUTLINE_EN to also exercise the outline request
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rect_plotter;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] x0;
   logic [6:0] y0;
   logic [7:0] width;
   logic [6:0] height;
   logic [2:0] colour_in;
   logic       step;
`ifdef RECT_OUTLINE_EN
   logic       outline;
`endif
   logic       busy;
   logic       done;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;

   int n_cmp;
   int n_err;

   rect_plotter #(.SCREEN_W(160), .SCREEN_H(120)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .x0        (x0),
      .y0        (y0),
      .width     (width),
      .height    (height),
      .colour_in (colour_in),
      .step      (step),
`ifdef RECT_OUTLINE_EN
      .outline   (outline),
`endif
      .busy      (busy),
      .done      (done),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .plot      (plot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance one rising edge; inputs and samples sit 1 unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input int px, input int py, input int pw, input int ph,
                          input int pc);
      x0        = 8'(px);
      y0        = 7'(py);
      width     = 8'(pw);
      height    = 7'(ph);
      colour_in = 3'(pc);
      start     = 1'b1;
   endtask

   initial begin
      int plots;
      int ex;
      int ey;
      int exp_x [12];
      int exp_y [12];
      int steps [7];

      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      start = 1'b0;
      x0 = '0; y0 = '0; width = '0; height = '0; colour_in = '0;
      step = 1'b1;
`ifdef RECT_OUTLINE_EN
      outline = 1'b0;
`endif
      #1;
      tick();
      tick();
      check_eq("rst_busy",   busy,   0);
      check_eq("rst_done",   done,   0);
      check_eq("rst_plot",   plot,   0);
      check_eq("rst_x",      x,      0);
      check_eq("rst_y",      y,      0);
      check_eq("rst_colour", colour, 0);
      reset = 1'b1;
      tick();

      // ---- 1: single 126-pixel row ----
      request(15, 20, 126, 1, 7);
      tick();
      start = 1'b0;
      check_eq("t1_busy_k", busy, 1);
      check_eq("t1_plot_k", plot, 0);
      for (int i = 0; i < 126; i++) begin
         tick();
         check_eq("t1_plot",   plot,   1);
         check_eq("t1_x",      x,      15 + i);
         check_eq("t1_y",      y,      20);
         check_eq("t1_colour", colour, 7);
         check_eq("t1_done",   done,   (i == 125) ? 1 : 0);
      end
      tick();
      check_eq("t1_end_done", done, 0);
      check_eq("t1_end_busy", busy, 0);
      check_eq("t1_end_plot", plot, 0);

      // ---- 2: 3x2 block ----
      request(10, 10, 3, 2, 4);
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check_eq("t2_plot",   plot,   1);
         check_eq("t2_x",      x,      10 + (i % 3));
         check_eq("t2_y",      y,      10 + (i / 3));
         check_eq("t2_colour", colour, 4);
         check_eq("t2_busy",   busy,   1);
         check_eq("t2_done",   done,   (i == 5) ? 1 : 0);
      end
      tick();
      check_eq("t2_end_busy", busy, 0);

      // ---- 3: clipping at bottom-right corner ----
      request(158, 118, 4, 4, 2);
      tick();
      start = 1'b0;
      plots = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         ex = 158 + (i % 4);
         ey = 118 + (i / 4);
         check_eq("t3_x",    x,    ex);
         check_eq("t3_y",    y,    ey);
         check_eq("t3_plot", plot, (ex < 160 && ey < 120) ? 1 : 0);
         check_eq("t3_done", done, (i == 15) ? 1 : 0);
         if (plot) plots++;
      end
      check_eq("t3_plot_count", plots, 4);
      tick();

      // ---- 4: empty request, then immediate follow-up held on start ----
      request(0, 0, 0, 5, 1);
      tick();
      check_eq("t4_busy_k", busy, 1);
      check_eq("t4_done_k", done, 1);
      check_eq("t4_plot_k", plot, 0);
      request(5, 6, 1, 1, 3);
      tick();
      check_eq("t4_idle_busy", busy, 0);
      check_eq("t4_idle_done", done, 0);
      tick();
      start = 1'b0;
      check_eq("t4_accept_busy", busy, 1);
      tick();
      check_eq("t4_px_plot", plot, 1);
      check_eq("t4_px_x",    x,    5);
      check_eq("t4_px_y",    y,    6);
      check_eq("t4_px_done", done, 1);
      tick();

      // ---- 5: step gaps, ignored start, reset mid-draw ----
      steps = '{1, 0, 0, 1, 1, 0, 1};
      request(20, 30, 4, 1, 5);
      tick();
      plots = 0;
      for (int i = 0; i < 7; i++) begin
         step = steps[i][0];
         if (i == 2) request(100, 100, 1, 1, 1);
         else start = 1'b0;
         tick();
         check_eq("t5_plot", plot, steps[i]);
         check_eq("t5_busy", busy, 1);
         if (steps[i] != 0) begin
            check_eq("t5_x", x, 20 + plots);
            check_eq("t5_y", y, 30);
            plots++;
         end
         check_eq("t5_done", done, (i == 6) ? 1 : 0);
      end
      step = 1'b1;
      start = 1'b0;
      tick();
      check_eq("t5_end_busy", busy, 0);

      request(40, 50, 10, 2, 6);
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      check_eq("t5_mid_plot", plot, 1);
      reset = 1'b0;
      tick();
      check_eq("t5_rst_busy",   busy,   0);
      check_eq("t5_rst_plot",   plot,   0);
      check_eq("t5_rst_x",      x,      0);
      check_eq("t5_rst_y",      y,      0);
      check_eq("t5_rst_colour", colour, 0);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("t5_post_done", done, 0);
         check_eq("t5_post_plot", plot, 0);
      end

`ifdef RECT_OUTLINE_EN
      // ---- 6: 4x4 outline ----
      exp_x = '{0, 1, 2, 3, 0, 3, 0, 3, 0, 1, 2, 3};
      exp_y = '{0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 3, 3};
      outline = 1'b1;
      request(0, 0, 4, 4, 1);
      tick();
      start = 1'b0;
      outline = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         check_eq("t6_plot", plot, 1);
         check_eq("t6_x",    x,    exp_x[i]);
         check_eq("t6_y",    y,    exp_y[i]);
         check_eq("t6_done", done, (i == 11) ? 1 : 0);
      end
      tick();
      check_eq("t6_end_busy", busy, 0);
`else
      exp_x = '{default: 0};
      exp_y = '{default: 0};
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rect_plotter.md
Name: rect_plotter

Overview:
Pixel-stream generator between the game control/datapath and vga_adapter (160x120, 3-bit colour).
- Accepts one rectangle request per start handshake: origin, size, colour.
- Emits one (x, y, colour, plot) pixel per enabled cycle, raster order.
- Clips off-screen pixels and pulses done when the request is finished.
- Replaces per-object hand-built x/y counters for borders, paddles and ball.

Parameters:
SCREEN_W, 160, visible columns; x >= SCREEN_W is clipped
SCREEN_H, 120, visible rows; y >= SCREEN_H is clipped

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  synchronous, active-low
start  in  1  request strobe; sampled only in IDLE
x0  in  8  rectangle left column
y0  in  7  rectangle top row
width  in  8  columns, 0..255; 0 = empty request
height  in  7  rows, 0..127; 0 = empty request
colour_in  in  3  fill colour
step  in  1  pixel-advance enable (tie 1 for full speed, or drive from a frame-rate tick)
busy  out  1  request in progress
done  out  1  one-cycle completion pulse
x  out  8  pixel column to vga_adapter
y  out  7  pixel row to vga_adapter
colour  out  3  pixel colour to vga_adapter
plot  out  1  write strobe to vga_adapter

Behaviour:
Interface:
- Reset is reset, synchronous, active-low; clock is clk.
- reset=0 at any edge: state IDLE; busy, done, plot, x, y and colour all 0. Any request in flight is aborted with no done pulse.

State machine: IDLE, DRAW, DONE.
- IDLE:
  - busy=0.
  - start=1 at edge k latches x0, y0, width, height and colour_in into internal registers; dx=0, dy=0.
  - If width==0 or height==0, go to DONE. Otherwise go to DRAW.
  - busy=1 from after edge k.
- DRAW:
  - At each edge with step=1:
    - x <= x0+dx and y <= y0+dy (truncated to port width); colour <= latched colour.
    - plot <= 1 only if the 9-bit sum x0+dx < SCREEN_W and the 8-bit sum y0+dy < SCREEN_H; otherwise plot <= 0 but the slot is still consumed.
    - If dx == width-1: dx <= 0 and dy <= dy+1. Otherwise dx <= dx+1.
    - On the last pixel (dx==width-1, dy==height-1), go to DONE at the same edge.
  - At each edge with step=0: plot <= 0; dx, dy, x and y hold.
  - start is ignored while busy.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then IDLE.
  - The last pixel's plot coincides with the done cycle.
  - plot <= 0 at the DONE->IDLE edge.
  - start is ignored in DONE; it is re-sampled the cycle after.

Timing:
- With step held at 1, pixel i (0-based) appears after edge k+1+i.
- done is high after edge k+W*H.
- An empty request has done high after edge k with no plot.
- Back-to-back requests: start may be held high; the next request is accepted at the first IDLE edge.

Widths and wrap-around:
- dx is 8-bit and dy is 7-bit.
- Coordinate sums use one extra bit, so wrap-around never produces a false visible pixel. Example: x0=150, width=20 gives plot=0 for dx 10..19.

Outputs:
- All outputs are registered and glitch-free.
- colour holds the latched value until the next accepted request.

Optional Feature:
RECT_OUTLINE_EN
- Defined:
  - Adds input port outline (1 bit), latched with start.
  - When outline=1, only perimeter pixels are generated. On rows 0 and height-1, every dx is generated. On interior rows, dx goes 0 then width-1, then the next row.
  - Pixel count is 2W+2(H-2) for W,H >= 2. W=1 or H=1 behaves as filled.
  - outline=0 behaves as filled.
- Undefined:
  - No outline port; always filled.
  - Generation order and timing are exactly as described above.

Test Plan:
1. Reset, then start with x0=15, y0=20, width=126, height=1, colour_in=7, step=1 -> 126 plot pulses, x 15..140, y=20, colour=7; done one cycle after edge k+126, coinciding with x=140.
2. x0=10, y0=10, W=3, H=2, colour_in=4 -> (10,10),(11,10),(12,10),(10,11),(11,11),(12,11) on consecutive cycles; busy high throughout; done with the 6th pixel.
3. x0=158, y0=118, W=4, H=4 -> 16 slots; plot=1 only for x in {158,159} and y in {118,119}, i.e. 4 plots; done after 16 slots.
4. W=0, H=5 -> busy and done high for one cycle after edge k; no plot. Then a new start in the following IDLE cycle is accepted.
5. W=4, H=1, step toggled 1,0,0,1,1,0,1 -> plot is 1 only after edges where step=1; x=0+offset,1,2,3 with gaps; a second start pulsed mid-draw is ignored. reset=0 mid-draw -> outputs 0 next edge, no done.
6. (RECT_OUTLINE_EN) x0=0, y0=0, W=4, H=4, outline=1 -> 12 pixels: row 0 x0..3; rows 1 and 2 x0 and x3; row 3 x0..3; done with the 12th.
